// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : mult_div_unit
// Description : Iterative shift-add multiply / restoring divide unit owning
//               the HI/LO register pair, with start/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int                 c_cnt_w = $clog2(WIDTH);
  localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [2*WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]     r_op_b;
  logic                 r_is_div;
  logic                 r_neg_res;
  logic                 r_neg_rem;
  logic                 r_div0;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;
  logic                 r_done;
  logic                 r_div_zero;

  logic                 w_signed;
  logic                 w_div0;
  logic [WIDTH-1:0]     w_mag_a;
  logic [WIDTH-1:0]     w_mag_b;
  logic [WIDTH:0]       w_mul_sum;
  logic [2*WIDTH-1:0]   w_mul_next;
  logic [WIDTH:0]       w_rem_sh;
  logic [WIDTH:0]       w_rem_diff;
  logic                 w_q_bit;
  logic [2*WIDTH-1:0]   w_div_next;
  logic [WIDTH-1:0]     w_quo;
  logic [WIDTH-1:0]     w_rem;
  logic [2*WIDTH-1:0]   w_prod_neg;
  logic [WIDTH-1:0]     w_res_hi;
  logic [WIDTH-1:0]     w_res_lo;

  // Operand conditioning at the accepting edge: magnitudes for signed ops
  assign w_signed = ~op[0];
  assign w_div0   = op[1] & (b == '0);
  assign w_mag_a  = (w_signed & a[WIDTH-1]) ? -a : a;
  assign w_mag_b  = (w_signed & b[WIDTH-1]) ? -b : b;

  // Radix-2 shift-add: conditional add into the upper half, then shift right
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
                      ({1'b0, r_op_b} & {(WIDTH+1){r_acc[0]}});
  assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

  // Restoring divide: upper half is the partial remainder, lower half shifts
  // the dividend out and the quotient bits in.
  assign w_rem_sh   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_rem_diff = w_rem_sh - {1'b0, r_op_b};
  assign w_q_bit    = ~w_rem_diff[WIDTH];
  assign w_div_next = {(w_q_bit ? w_rem_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0]),
                       r_acc[WIDTH-2:0], w_q_bit};

  assign w_quo      = r_acc[WIDTH-1:0];
  assign w_rem      = r_acc[2*WIDTH-1:WIDTH];
  assign w_prod_neg = -r_acc;

  always_comb begin
    w_res_hi = w_rem;
    w_res_lo = w_quo;
    if (r_div0) begin
      w_res_hi = r_acc[WIDTH-1:0];
      w_res_lo = '1;
    end else if (r_is_div) begin
      w_res_lo = r_neg_res ? -w_quo : w_quo;
      w_res_hi = r_neg_rem ? -w_rem : w_rem;
    end else if (r_neg_res) begin
      {w_res_hi, w_res_lo} = w_prod_neg;
    end else begin
      {w_res_hi, w_res_lo} = r_acc;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start) w_next = w_div0 ? S_FIN : S_CALC;
      S_CALC: if (r_cnt == c_last) w_next = S_FIN;
      S_FIN:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt      <= '0;
      r_acc      <= '0;
      r_op_b     <= '0;
      r_is_div   <= 1'b0;
      r_neg_res  <= 1'b0;
      r_neg_rem  <= 1'b0;
      r_div0     <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cnt     <= '0;
            r_is_div  <= op[1];
            r_neg_res <= w_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            r_neg_rem <= w_signed & a[WIDTH-1];
            r_div0    <= w_div0;
            r_op_b    <= w_mag_b;
            // Divide-by-zero keeps the raw dividend so it can be returned in HI
            r_acc     <= {{WIDTH{1'b0}}, (w_div0 ? a : w_mag_a)};
          end else begin
            if (hi_we) r_hi <= wdata;
            if (lo_we) r_lo <= wdata;
          end
        end
        S_CALC: begin
          r_acc <= r_is_div ? w_div_next : w_mul_next;
          r_cnt <= r_cnt + 1'b1;
        end
        S_FIN: begin
          r_hi       <= w_res_hi;
          r_lo       <= w_res_lo;
          r_done     <= 1'b1;
          r_div_zero <= r_div0;
        end
        default: ;
      endcase
    end
  end

  assign busy     = (r_state != S_IDLE);
  assign done     = r_done;
  assign div_zero = r_div_zero;
  assign hi       = r_hi;
  assign lo       = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_div_unit
// Description : Directed self-checking bench for mult_div_unit (WIDTH 32/16/8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_div_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op    = 2'd0;
  logic [31:0] a     = '0;
  logic [31:0] b     = '0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [31:0] wdata = '0;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  logic        sw_start = 1'b0;
  logic [1:0]  sw_op    = 2'd0;
  logic [15:0] sw_a     = '0;
  logic [15:0] sw_b     = '0;
  logic        sw_we    = 1'b0;
  logic        busy8, done8, dz8, busy16, done16, dz16;
  logic [7:0]  hi8, lo8;
  logic [15:0] hi16, lo16;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  mult_div_unit #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  mult_div_unit #(.WIDTH(8)) dut8 (
    .clock(clock), .reset(reset), .start(sw_start), .op(sw_op), .a(sw_a[7:0]), .b(sw_b[7:0]),
    .hi_we(sw_we), .lo_we(sw_we), .wdata(sw_a[7:0]),
    .busy(busy8), .done(done8), .div_zero(dz8), .hi(hi8), .lo(lo8)
  );

  mult_div_unit #(.WIDTH(16)) dut16 (
    .clock(clock), .reset(reset), .start(sw_start), .op(sw_op), .a(sw_a), .b(sw_b),
    .hi_we(sw_we), .lo_we(sw_we), .wdata(sw_a),
    .busy(busy16), .done(done16), .div_zero(dz16), .hi(hi16), .lo(lo16)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Arithmetic reference for a WIDTH=w unit
  function automatic void model(input int w, input logic [1:0] o,
                                input logic [15:0] a_in, input logic [15:0] b_in,
                                output logic [15:0] eh, output logic [15:0] el);
    longint mask, ua, ub, sa, sb, p, q, r;
    mask = (longint'(1) << w) - 1;
    ua = longint'(a_in) & mask;
    ub = longint'(b_in) & mask;
    sa = (((ua >> (w - 1)) & 1) != 0) ? ua - (mask + 1) : ua;
    sb = (((ub >> (w - 1)) & 1) != 0) ? ub - (mask + 1) : ub;
    if (o[1] == 1'b0) begin
      p  = (o[0] == 1'b0) ? sa * sb : ua * ub;
      el = 16'(p & mask);
      eh = 16'((p >>> w) & mask);
    end else if (ub == 0) begin
      eh = 16'(ua);
      el = 16'(mask);
    end else begin
      if (o[0] == 1'b0) begin
        q = sa / sb;
        r = sa % sb;
      end else begin
        q = ua / ub;
        r = ua % ub;
      end
      el = 16'(q & mask);
      eh = 16'(r & mask);
    end
  endfunction

  // Ends at the first negedge after the accepting edge; operands scrambled after
  task automatic launch(input logic [1:0] o, input logic [31:0] va, input logic [31:0] vb);
    @(negedge clock);
    start = 1'b1; op = o; a = va; b = vb;
    @(negedge clock);
    start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
  endtask

  task automatic wait_done(input int k0, output int k);
    k = k0;
    while (done !== 1'b1 && k < 100) begin
      @(negedge clock);
      k++;
    end
  endtask

  task automatic run32(input string tag, input logic [1:0] o, input logic [31:0] va,
                       input logic [31:0] vb, input logic [31:0] eh, input logic [31:0] el,
                       input logic edz, input int elat);
    int k;
    launch(o, va, vb);
    chk({tag, ".busy"}, 64'(busy), 64'd1);
    wait_done(0, k);
    chk({tag, ".latency"}, 64'(k), 64'(elat));
    chk({tag, ".hi"}, 64'(hi), 64'(eh));
    chk({tag, ".lo"}, 64'(lo), 64'(el));
    chk({tag, ".div_zero"}, 64'(div_zero), 64'(edz));
  endtask

  task automatic after_done(input string tag);
    @(negedge clock);
    chk({tag, ".done_pulse"}, 64'(done), 64'd0);
    chk({tag, ".idle"}, 64'(busy), 64'd0);
  endtask

  task automatic count_done(input string tag, input int cycles);
    int n;
    n = 0;
    repeat (cycles) begin
      @(negedge clock);
      if (done === 1'b1) n++;
    end
    chk({tag, ".no_done"}, 64'(n), 64'd0);
  endtask

  task automatic sweep(input logic [1:0] o, input logic [15:0] va, input logic [15:0] vb);
    logic [15:0] eh8, el8, eh16, el16;
    bit got8, got16;
    int k;
    model(8, o, va, vb, eh8, el8);
    model(16, o, va, vb, eh16, el16);
    @(negedge clock);
    sw_start = 1'b1; sw_op = o; sw_a = va; sw_b = vb;
    @(negedge clock);
    sw_start = 1'b0; sw_a = 16'($urandom); sw_b = 16'($urandom);
    got8 = 1'b0; got16 = 1'b0; k = 0;
    while (!(got8 && got16) && k < 40) begin
      if (done8 === 1'b1 && !got8) begin
        got8 = 1'b1;
        chk($sformatf("w8.op%0d.hi", o), 64'(hi8), 64'(eh8[7:0]));
        chk($sformatf("w8.op%0d.lo", o), 64'(lo8), 64'(el8[7:0]));
        chk($sformatf("w8.op%0d.dz", o), 64'(dz8), 64'(o[1] && vb[7:0] == 8'd0));
      end
      if (done16 === 1'b1 && !got16) begin
        got16 = 1'b1;
        chk($sformatf("w16.op%0d.hi", o), 64'(hi16), 64'(eh16));
        chk($sformatf("w16.op%0d.lo", o), 64'(lo16), 64'(el16));
        chk($sformatf("w16.op%0d.dz", o), 64'(dz16), 64'(o[1] && vb == 16'd0));
      end
      @(negedge clock);
      k++;
    end
    chk("sweep.both_done", {62'd0, got8, got16}, 64'd3);
  endtask

  initial begin
    int k;
    repeat (2) @(negedge clock);
    chk("reset.hi", 64'(hi), 64'd0);
    chk("reset.lo", 64'(lo), 64'd0);
    chk("reset.busy", 64'(busy), 64'd0);
    chk("reset.done", 64'(done), 64'd0);
    chk("reset.div_zero", 64'(div_zero), 64'd0);
    reset = 1'b1;

    run32("mult", 2'd0, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0, 33);
    after_done("mult");
    run32("multu", 2'd1, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA, 1'b0, 33);
    after_done("multu");
    run32("mult_negneg", 2'd0, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 32'd0, 32'd15, 1'b0, 33);
    after_done("mult_negneg");
    run32("div", 2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33);
    after_done("div");
    run32("div_negb", 2'd2, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0, 33);
    after_done("div_negb");
    run32("divu", 2'd3, 32'd7, 32'd2, 32'd1, 32'd3, 1'b0, 33);
    after_done("divu");
    run32("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 33);
    after_done("div_ovf");
    run32("divu_zero", 2'd3, 32'h1234, 32'd0, 32'h1234, 32'hFFFF_FFFF, 1'b1, 1);
    after_done("divu_zero");
    chk("divu_zero.dz_pulse", 64'(div_zero), 64'd0);
    run32("multu_after_dz", 2'd1, 32'h0001_0000, 32'h0001_0000, 32'd1, 32'd0, 1'b0, 33);
    after_done("multu_after_dz");

    // Reset in the middle of CALC aborts with no done
    launch(2'd1, 32'd5, 32'd7);
    repeat (10) @(negedge clock);
    reset = 1'b0;
    #1;
    chk("midreset.hi", 64'(hi), 64'd0);
    chk("midreset.lo", 64'(lo), 64'd0);
    chk("midreset.busy", 64'(busy), 64'd0);
    @(negedge clock);
    reset = 1'b1;
    count_done("midreset", 40);

    // start pulsed mid-CALC with new operands is ignored
    launch(2'd1, 32'd1000, 32'd1000);
    repeat (5) @(negedge clock);
    start = 1'b1; a = 32'd9; b = 32'd9;
    @(negedge clock);
    start = 1'b0;
    wait_done(6, k);
    chk("midstart.latency", 64'(k), 64'd33);
    chk("midstart.hi", 64'(hi), 64'd0);
    chk("midstart.lo", 64'(lo), 64'h000F_4240);
    after_done("midstart");
    count_done("midstart", 40);

    // Back-to-back: start during the done cycle
    run32("b2b_first", 2'd3, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 33);
    start = 1'b1; op = 2'd0; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
    @(negedge clock);
    start = 1'b0;
    chk("b2b_second.busy", 64'(busy), 64'd1);
    wait_done(0, k);
    chk("b2b_second.latency", 64'(k), 64'd33);
    chk("b2b_second.hi", 64'(hi), 64'd0);
    chk("b2b_second.lo", 64'(lo), 64'd1);
    after_done("b2b_second");

    // HI/LO direct writes
    hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
    @(negedge clock);
    hi_we = 1'b0;
    chk("mthi.hi", 64'(hi), 64'hDEAD_BEEF);
    chk("mthi.lo", 64'(lo), 64'd1);
    lo_we = 1'b1; wdata = 32'h55;
    @(negedge clock);
    lo_we = 1'b0;
    chk("mtlo.lo", 64'(lo), 64'h55);
    chk("mtlo.hi", 64'(hi), 64'hDEAD_BEEF);

    launch(2'd1, 32'd2, 32'd3);
    lo_we = 1'b1; wdata = 32'hAAAA;
    @(negedge clock);
    lo_we = 1'b0;
    chk("mtlo_busy.lo", 64'(lo), 64'h55);
    wait_done(1, k);
    chk("mtlo_busy.latency", 64'(k), 64'd33);
    chk("mtlo_busy.lo_result", 64'(lo), 64'd6);
    after_done("mtlo_busy");

    @(negedge clock);
    start = 1'b1; op = 2'd1; a = 32'h11; b = 32'h11; hi_we = 1'b1; wdata = 32'h1234_5678;
    @(negedge clock);
    start = 1'b0; hi_we = 1'b0;
    chk("start_mthi.busy", 64'(busy), 64'd1);
    chk("start_mthi.hi_dropped", 64'(hi), 64'd0);
    wait_done(0, k);
    chk("start_mthi.lo", 64'(lo), 64'h121);
    after_done("start_mthi");

    // WIDTH 8 / 16 against the reference model
    sweep(2'd2, 16'h8000, 16'hFFFF);
    sweep(2'd2, 16'hFF80, 16'hFFFF);
    sweep(2'd3, 16'h00A5, 16'h0000);
    sweep(2'd0, 16'hFF80, 16'hFF80);
    for (int i = 0; i < 16; i++) begin
      sweep(2'(i % 4), 16'($urandom), 16'($urandom));
    end
    chk("sweep.idle8", 64'(busy8), 64'd0);
    chk("sweep.idle16", 64'(busy16), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
